// File: rtl/lc3b_types.sv
// Shared LC-3b memory-hierarchy types: word and cacheline widths, the
// L2 arbiter grant select and the arbiter state encoding.
package lc3b_types;

    localparam int LC3B_WORD_W      = 16;
    localparam int LC3B_CACHELINE_W = 128;

    typedef logic [LC3B_WORD_W-1:0]      lc3b_word;
    typedef logic [LC3B_CACHELINE_W-1:0] lc3b_cacheline;

    // Which L1 owns (or last owned) the shared L2 port
    typedef enum logic {
        ARB_GRANT_I = 1'b0,
        ARB_GRANT_D = 1'b1
    } lc3b_arb_grant;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        SERVE_I  = 2'd1,
        SERVE_D  = 2'd2
    } lc3b_arb_state;

    // A line request is valid only when exactly one of read/write is set
    function automatic logic lc3b_req_valid(input logic rd, input logic wr);
        return rd ^ wr;
    endfunction

endpackage

// File: rtl/l2_req_mux.sv
// Steers the granted L1's request onto the shared L2 port; the port is
// held at zero whenever no grant is active so L2 never sees a stale request.
module l2_req_mux
    import lc3b_types::*;
(
    input  logic          active,
    input  lc3b_arb_grant grant,
    input  logic          i_l2_read,
    input  logic          i_l2_write,
    input  lc3b_word      i_l2_address,
    input  lc3b_cacheline i_l2_wdata,
    input  logic          d_l2_read,
    input  logic          d_l2_write,
    input  lc3b_word      d_l2_address,
    input  lc3b_cacheline d_l2_wdata,
    output logic          l2_read,
    output logic          l2_write,
    output lc3b_word      l2_address,
    output lc3b_cacheline l2_wdata
);

    // 2:1 select by grant, forced to zero while idle
    always_comb begin
        l2_read    = 1'b0;
        l2_write   = 1'b0;
        l2_address = '0;
        l2_wdata   = '0;
        if (active) begin
            if (grant == ARB_GRANT_D) begin
                l2_read    = d_l2_read;
                l2_write   = d_l2_write;
                l2_address = d_l2_address;
                l2_wdata   = d_l2_wdata;
            end else begin
                l2_read    = i_l2_read;
                l2_write   = i_l2_write;
                l2_address = i_l2_address;
                l2_wdata   = i_l2_wdata;
            end
        end
    end

endmodule

// File: rtl/l2_arbiter.sv
// Round-robin arbiter between the I-L1 and D-L1 controllers for the single
// shared L2 port. Requests are passed through combinationally once granted,
// the response is routed only to the owner, read data is broadcast.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ARB_IDLE | no owner; L2 port at zero; pick next owner round-robin
//   SERVE_I  | I-L1 owns L2 until l2_resp, then back to ARB_IDLE
//   SERVE_D  | D-L1 owns L2 until l2_resp, then back to ARB_IDLE
module l2_arbiter
    import lc3b_types::*;
#(
    parameter bit RESET_PRIO_D = 1'b1
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          i_l2_read,
    input  logic          i_l2_write,
    input  lc3b_word      i_l2_address,
    input  lc3b_cacheline i_l2_wdata,
    output logic          i_l2_resp,
    output lc3b_cacheline i_l2_rdata,

    input  logic          d_l2_read,
    input  logic          d_l2_write,
    input  lc3b_word      d_l2_address,
    input  lc3b_cacheline d_l2_wdata,
    output logic          d_l2_resp,
    output lc3b_cacheline d_l2_rdata,

    output logic          l2_read,
    output logic          l2_write,
    output lc3b_word      l2_address,
    output lc3b_cacheline l2_wdata,
    input  logic          l2_resp,
    input  lc3b_cacheline l2_rdata,

    output logic          arb_conflict_inc
);

    // last_grant starts on the side that should lose the first tie
    localparam lc3b_arb_grant RESET_LAST_GRANT = RESET_PRIO_D ? ARB_GRANT_I : ARB_GRANT_D;

    lc3b_arb_state state;
    lc3b_arb_grant last_grant;
    logic          req_i;
    logic          req_d;
    logic          serving;
    lc3b_arb_grant grant_sel;

    assign req_i = lc3b_req_valid(i_l2_read, i_l2_write);
    assign req_d = lc3b_req_valid(d_l2_read, d_l2_write);

    // Arbitration FSM and round-robin history
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ARB_IDLE;
            last_grant <= RESET_LAST_GRANT;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (req_i && req_d) begin
                        if (last_grant == ARB_GRANT_D) begin
                            state <= SERVE_I;
                        end else begin
                            state <= SERVE_D;
                        end
                    end else if (req_i) begin
                        state <= SERVE_I;
                    end else if (req_d) begin
                        state <= SERVE_D;
                    end
                end
                SERVE_I: begin
                    if (l2_resp) begin
                        last_grant <= ARB_GRANT_I;
                        state      <= ARB_IDLE;
                    end
                end
                SERVE_D: begin
                    if (l2_resp) begin
                        last_grant <= ARB_GRANT_D;
                        state      <= ARB_IDLE;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    // Owner select; reset masks the port so nothing leaks during the reset cycle
    always_comb begin
        serving   = !reset && (state == SERVE_I || state == SERVE_D);
        grant_sel = (state == SERVE_D) ? ARB_GRANT_D : ARB_GRANT_I;
    end

    l2_req_mux u_req_mux (
        .active       (serving),
        .grant        (grant_sel),
        .i_l2_read    (i_l2_read),
        .i_l2_write   (i_l2_write),
        .i_l2_address (i_l2_address),
        .i_l2_wdata   (i_l2_wdata),
        .d_l2_read    (d_l2_read),
        .d_l2_write   (d_l2_write),
        .d_l2_address (d_l2_address),
        .d_l2_wdata   (d_l2_wdata),
        .l2_read      (l2_read),
        .l2_write     (l2_write),
        .l2_address   (l2_address),
        .l2_wdata     (l2_wdata)
    );

    // Response demux to the owner only, tie pulse, read-data broadcast
    always_comb begin
        i_l2_resp        = !reset && (state == SERVE_I) && l2_resp;
        d_l2_resp        = !reset && (state == SERVE_D) && l2_resp;
        arb_conflict_inc = !reset && (state == ARB_IDLE) && req_i && req_d;
        i_l2_rdata       = l2_rdata;
        d_l2_rdata       = l2_rdata;
    end

endmodule

// File: tb/tb_l2_arbiter.sv
module tb_l2_arbiter;
    import lc3b_types::*;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_l2_read, i_l2_write;
    lc3b_word      i_l2_address;
    lc3b_cacheline i_l2_wdata;
    logic          i_l2_resp;
    lc3b_cacheline i_l2_rdata;
    logic          d_l2_read, d_l2_write;
    lc3b_word      d_l2_address;
    lc3b_cacheline d_l2_wdata;
    logic          d_l2_resp;
    lc3b_cacheline d_l2_rdata;
    logic          l2_read, l2_write;
    lc3b_word      l2_address;
    lc3b_cacheline l2_wdata;
    logic          l2_resp;
    lc3b_cacheline l2_rdata;
    logic          arb_conflict_inc;

    int tests_run    = 0;
    int tests_failed = 0;

    localparam lc3b_cacheline WD_A = 128'h0123456789abcdef_fedcba9876543210;
    localparam lc3b_cacheline WD_B = 128'hcafef00d_00000001_deadbeef_55aa55aa;
    localparam lc3b_cacheline RD_A = 128'h11112222_33334444_55556666_77778888;

    l2_arbiter #(.RESET_PRIO_D(1'b1)) dut (
        .clk(clk), .reset(reset),
        .i_l2_read(i_l2_read), .i_l2_write(i_l2_write), .i_l2_address(i_l2_address),
        .i_l2_wdata(i_l2_wdata), .i_l2_resp(i_l2_resp), .i_l2_rdata(i_l2_rdata),
        .d_l2_read(d_l2_read), .d_l2_write(d_l2_write), .d_l2_address(d_l2_address),
        .d_l2_wdata(d_l2_wdata), .d_l2_resp(d_l2_resp), .d_l2_rdata(d_l2_rdata),
        .l2_read(l2_read), .l2_write(l2_write), .l2_address(l2_address),
        .l2_wdata(l2_wdata), .l2_resp(l2_resp), .l2_rdata(l2_rdata),
        .arb_conflict_inc(arb_conflict_inc)
    );

    always #5 clk = ~clk;

    // inputs change 2 time units after the edge, outputs are sampled 1 unit later
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs();
        i_l2_read = 0; i_l2_write = 0; i_l2_address = '0; i_l2_wdata = '0;
        d_l2_read = 0; d_l2_write = 0; d_l2_address = '0; d_l2_wdata = '0;
        l2_resp = 0; l2_rdata = '0;
    endtask

    task automatic do_reset();
        reset = 1;
        tick();
        tick();
        reset = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1;
        i_l2_read = 1; d_l2_read = 1; l2_resp = 1;
        tick();
        tick();
        #1;
        tests_run++;
        if ({l2_read, l2_write, i_l2_resp, d_l2_resp, arb_conflict_inc} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_outs got %b exp 00000", {l2_read, l2_write, i_l2_resp, d_l2_resp, arb_conflict_inc});
        end
        tests_run++;
        if (l2_address !== 16'h0 || l2_wdata !== '0) begin
            tests_failed++;
            $display("FAIL reset_bus got addr %h exp 0000", l2_address);
        end
        clear_inputs();
        reset = 0;
        tick();
        #1;
        tests_run++;
        if ({l2_read, l2_write, i_l2_resp, d_l2_resp, arb_conflict_inc} !== 5'b0) begin
            tests_failed++;
            $display("FAIL post_reset_outs got %b exp 00000", {l2_read, l2_write, i_l2_resp, d_l2_resp, arb_conflict_inc});
        end
    endtask

    task automatic test_d_only_read();
        do_reset();
        d_l2_read = 1; d_l2_address = 16'h1230; l2_rdata = RD_A;
        #1;
        tests_run++;
        if (l2_read !== 1'b0) begin
            tests_failed++;
            $display("FAIL dread_c0_idle got %b exp 0", l2_read);
        end
        for (int c = 1; c <= 5; c++) begin
            tick();
            l2_resp = (c == 5);
            #1;
            tests_run++;
            if (l2_read !== 1'b1 || l2_write !== 1'b0 || l2_address !== 16'h1230) begin
                tests_failed++;
                $display("FAIL dread_c%0d_req got rd %b wr %b addr %h exp 1 0 1230", c, l2_read, l2_write, l2_address);
            end
            tests_run++;
            if (d_l2_resp !== (c == 5) || i_l2_resp !== 1'b0) begin
                tests_failed++;
                $display("FAIL dread_c%0d_resp got d %b i %b exp %b 0", c, d_l2_resp, i_l2_resp, (c == 5));
            end
        end
        tests_run++;
        if (d_l2_rdata !== RD_A || i_l2_rdata !== RD_A) begin
            tests_failed++;
            $display("FAIL rdata_bcast got d %h i %h exp %h", d_l2_rdata, i_l2_rdata, RD_A);
        end
        tick();
        clear_inputs();
        #1;
        tests_run++;
        if (l2_read !== 1'b0 || d_l2_resp !== 1'b0) begin
            tests_failed++;
            $display("FAIL dread_c6_idle got rd %b resp %b exp 0 0", l2_read, d_l2_resp);
        end
    endtask

    task automatic test_conflict();
        do_reset();
        i_l2_read = 1; i_l2_address = 16'h0400;
        d_l2_write = 1; d_l2_address = 16'h8000; d_l2_wdata = WD_A;
        #1;
        tests_run++;
        if (arb_conflict_inc !== 1'b1) begin
            tests_failed++;
            $display("FAIL conf_pulse got %b exp 1", arb_conflict_inc);
        end
        tick();
        #1;
        tests_run++;
        if (l2_write !== 1'b1 || l2_read !== 1'b0 || l2_address !== 16'h8000 || l2_wdata !== WD_A) begin
            tests_failed++;
            $display("FAIL conf_d_first got rd %b wr %b addr %h exp 0 1 8000", l2_read, l2_write, l2_address);
        end
        tests_run++;
        if (arb_conflict_inc !== 1'b0) begin
            tests_failed++;
            $display("FAIL conf_single_pulse got %b exp 0", arb_conflict_inc);
        end
        tick();
        l2_resp = 1;
        #1;
        tests_run++;
        if (d_l2_resp !== 1'b1 || i_l2_resp !== 1'b0) begin
            tests_failed++;
            $display("FAIL conf_d_resp got d %b i %b exp 1 0", d_l2_resp, i_l2_resp);
        end
        tick();
        l2_resp = 0; d_l2_write = 0;
        #1;
        tests_run++;
        if (l2_read !== 1'b0 || l2_write !== 1'b0 || arb_conflict_inc !== 1'b0) begin
            tests_failed++;
            $display("FAIL conf_gap_idle got rd %b wr %b conf %b exp 0 0 0", l2_read, l2_write, arb_conflict_inc);
        end
        tick();
        l2_resp = 1;
        #1;
        tests_run++;
        if (l2_read !== 1'b1 || l2_address !== 16'h0400 || i_l2_resp !== 1'b1 || d_l2_resp !== 1'b0) begin
            tests_failed++;
            $display("FAIL conf_i_second got rd %b addr %h iresp %b exp 1 0400 1", l2_read, l2_address, i_l2_resp);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        do_reset();
        i_l2_read = 1; i_l2_address = 16'h0111;
        d_l2_write = 1; d_l2_address = 16'h2220; d_l2_wdata = WD_B;
        tick();
        l2_resp = 1;
        #1;
        tests_run++;
        if (l2_write !== 1'b1 || l2_address !== 16'h2220 || l2_wdata !== WD_B || d_l2_resp !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_g0_d got wr %b addr %h dresp %b exp 1 2220 1", l2_write, l2_address, d_l2_resp);
        end
        tick();
        l2_resp = 0; d_l2_write = 0; d_l2_read = 1; d_l2_address = 16'h2240;
        #1;
        tests_run++;
        if (l2_read !== 1'b0 || l2_write !== 1'b0 || arb_conflict_inc !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_idle1 got rd %b wr %b conf %b exp 0 0 1", l2_read, l2_write, arb_conflict_inc);
        end
        tick();
        l2_resp = 1;
        #1;
        tests_run++;
        if (l2_read !== 1'b1 || l2_address !== 16'h0111 || i_l2_resp !== 1'b1 || d_l2_resp !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_g1_i got rd %b addr %h iresp %b dresp %b exp 1 0111 1 0", l2_read, l2_address, i_l2_resp, d_l2_resp);
        end
        tick();
        l2_resp = 0;
        #1;
        tests_run++;
        if (l2_read !== 1'b0 || arb_conflict_inc !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_idle2 got rd %b conf %b exp 0 1", l2_read, arb_conflict_inc);
        end
        tick();
        l2_resp = 1;
        #1;
        tests_run++;
        if (l2_read !== 1'b1 || l2_address !== 16'h2240 || d_l2_resp !== 1'b1 || i_l2_resp !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_g2_d got rd %b addr %h dresp %b iresp %b exp 1 2240 1 0", l2_read, l2_address, d_l2_resp, i_l2_resp);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_idle_resp();
        do_reset();
        l2_resp = 1;
        for (int c = 0; c < 2; c++) begin
            #1;
            tests_run++;
            if (i_l2_resp !== 1'b0 || d_l2_resp !== 1'b0 || l2_read !== 1'b0) begin
                tests_failed++;
                $display("FAIL idle_resp_c%0d got i %b d %b rd %b exp 0 0 0", c, i_l2_resp, d_l2_resp, l2_read);
            end
            tick();
        end
        l2_resp = 0;
        d_l2_read = 1; d_l2_address = 16'h0abc;
        #1;
        tests_run++;
        if (l2_read !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_resp_still_idle got %b exp 0", l2_read);
        end
        tick();
        #1;
        tests_run++;
        if (l2_read !== 1'b1 || l2_address !== 16'h0abc || d_l2_resp !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_resp_later got rd %b addr %h dresp %b exp 1 0abc 0", l2_read, l2_address, d_l2_resp);
        end
        l2_resp = 1;
        #1;
        tests_run++;
        if (d_l2_resp !== 1'b1) begin
            tests_failed++;
            $display("FAIL idle_resp_later_resp got %b exp 1", d_l2_resp);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        i_l2_read = 1; i_l2_address = 16'h0500;
        tick();
        d_l2_read = 1; d_l2_address = 16'h0600;
        #1;
        tests_run++;
        if (l2_read !== 1'b1 || l2_address !== 16'h0500) begin
            tests_failed++;
            $display("FAIL rmid_serve_i got rd %b addr %h exp 1 0500", l2_read, l2_address);
        end
        tick();
        reset = 1; l2_resp = 1;
        #1;
        tests_run++;
        if (i_l2_resp !== 1'b0 || d_l2_resp !== 1'b0) begin
            tests_failed++;
            $display("FAIL rmid_no_resp got i %b d %b exp 0 0", i_l2_resp, d_l2_resp);
        end
        tick();
        reset = 0; l2_resp = 0;
        #1;
        tests_run++;
        if (l2_read !== 1'b0 || arb_conflict_inc !== 1'b1) begin
            tests_failed++;
            $display("FAIL rmid_idle got rd %b conf %b exp 0 1", l2_read, arb_conflict_inc);
        end
        tick();
        l2_resp = 1;
        #1;
        tests_run++;
        if (l2_read !== 1'b1 || l2_address !== 16'h0600 || d_l2_resp !== 1'b1 || i_l2_resp !== 1'b0) begin
            tests_failed++;
            $display("FAIL rmid_d_first got rd %b addr %h dresp %b iresp %b exp 1 0600 1 0", l2_read, l2_address, d_l2_resp, i_l2_resp);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_invalid_req();
        do_reset();
        i_l2_read = 1; i_l2_write = 1; i_l2_address = 16'h0777;
        for (int c = 0; c < 10; c++) begin
            #1;
            tests_run++;
            if (l2_read !== 1'b0 || l2_write !== 1'b0 || arb_conflict_inc !== 1'b0) begin
                tests_failed++;
                $display("FAIL invalid_c%0d got rd %b wr %b conf %b exp 0 0 0", c, l2_read, l2_write, arb_conflict_inc);
            end
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        reset = 1;
        clear_inputs();
        test_reset();
        test_d_only_read();
        test_conflict();
        test_back_to_back();
        test_idle_resp();
        test_reset_mid();
        test_invalid_req();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
